osd_mam_pktgen: RTL and testbench
=================================

// Module: osd_mam_pktgen
// PURPOSE
//  Host-side MAM request packetizer. Converts a memory request (addr, beats) plus a write-data stream into
//  dii_flit packets for a MAM on the debug ring: dest, src, MAM header, address, data.
//  Bursts are split into ring packets of at most MAX_PKT_LEN flits. Width-generic in data and address.
//  Sits between host/DMA logic and a debug ring port (debug_in[k] of debug_ring).
// PARAMETERS
//  DATA_WIDTH   16  memory word width; multiple of 16; WF = DATA_WIDTH/16 flits per word
//  ADDR_WIDTH   32  address width; multiple of 16; AF = ADDR_WIDTH/16 address flits
//  MAX_PKT_LEN  8   max flits per ring packet incl. dest+src; must satisfy MAX_PKT_LEN >= 3+AF and >= 2+WF
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           asynchronous reset, active low
//  id           in   10          own module id (src field)
//  mam_id       in   10          target MAM id (dest field)
//  req_valid    in   1           request valid
//  req_ready    out  1           request accepted when valid&ready
//  req_rw       in   1           1=write, 0=read
//  req_addr     in   ADDR_WIDTH  start address
//  req_burst    in   1           1=burst, 0=single
//  req_beats    in   14          burst length in words (ignored if !req_burst)
//  wdata_valid  in   1           write word valid
//  wdata        in   DATA_WIDTH  write word
//  wdata_ready  out  1           word consumed when valid&ready
//  debug_out    out  dii_flit    flit to ring (data, valid, last)
//  debug_out_ready in 1          ring accepts flit
//  busy         out  1           request in progress (state != IDLE)
// BEHAVIOUR
//  Reset (async, rst_n=0): debug_out.valid/last/data=0, req_ready=0 during reset then 1, wdata_ready=0, busy=0,
//   all counters 0, FSM->IDLE. Reset mid-packet truncates the packet; the ring port is reset by the same rst_n.
//  Flit formats: dest={6'h0,mam_id}; src={MAM_REQ_TYPE=6'h10,id}; hdr={rw,burst,beats[13:0]} (beats=0 if single);
//   address MSB flit first; word MSB flit first. debug_out is a register; a flit, once valid, holds data/last
//   stable until debug_out_ready. New flit loaded when slot free: !debug_out.valid || debug_out_ready.
//  Capacity: first packet W0 = (MAX_PKT_LEN-3-AF)/WF words, continuation packets WC = (MAX_PKT_LEN-2)/WF
//   words (floor); words never straddle packets. N = burst ? req_beats : 1 words; N=0 for reads.
//  FSM: IDLE -> DEST -> SRC -> HDR -> ADDR(AF flits) -> DATA -> [DEST -> SRC -> DATA]* -> IDLE.
//   IDLE: req_ready=1; on handshake latch rw/addr/N, goto DEST; first flit valid on the following cycle.
//   ADDR: after last addr flit: if rw=0, N=0 or W0=0 -> last=1 on that flit; then IDLE if N=0/read, else DEST.
//   DATA: at word-flit index 0, wdata_ready = slot free; word latched into WF-flit shift register; if
//    wdata_valid=0 a bubble (valid=0) is inserted, packet stays open. last=1 on final flit of final word
//    in packet (packet word count reached, or remaining words=0). Then DEST if words remain, else IDLE.
//  Counters: words_left 14b (decrements per consumed word); pkt_words, flit_idx, addr_idx sized by $clog2.
//  Burst with req_beats=0: header c000-type with beats 0, address packet ends with last, no data flits.
//  Throughput: one flit/cycle with ready=1 and wdata_valid=1; no bubble between packets or between requests
//   except the single IDLE cycle after the final flit.
// STRUCTURE
//  Shared package osd_mam_pkg: MAM_REQ_TYPE=6'h10, header bit positions (HDR_RW=15, HDR_BURST=14,
//   HDR_BEATS=13:0), state enum typedef. dii_flit from dii_package.
//  One sub-module: mam_word_serializer (DATA_WIDTH -> 16-bit flits, load/shift, flit_idx, done flag).
// TESTING (DATA_WIDTH=16, ADDR_WIDTH=32, MAX_PKT_LEN=8, id=0, mam_id=1 unless noted)
//  1 single write addr 0, word 000f -> 0001,4000,8000,0000,0000,000f(last); busy low next cycle.
//  2 burst write beats=6, words 0000..0005 -> 0001,4000,c006,0000,0000,0000,0001,0002(last);
//    0001,4000,0003,0004,0005(last).
//  3 burst read addr 0000_0100 beats=4 -> 0001,4000,4004,0000,0100(last); wdata_ready never 1.
//  4 DATA_WIDTH=32: burst beats=2, words 1234_5678, 9abc_def0 -> ...,c002,a_hi,a_lo,1234,5678,9abc(last? no),
//    W0=1 so: pkt1 ends 5678(last); pkt2 0001,4000,9abc,def0(last).
//  5 test 2 with debug_out_ready random 50% and wdata_valid gaps -> identical flit sequence, data stable
//    while valid&!ready, bubbles carry valid=0, no spurious last.
//  6 rst_n low during DATA of test 2 -> debug_out.valid=0 immediately; after release, test 1 output exact.

Source files
------------

// File: rtl/osd_mam_pktgen_pkg.sv
// Shared definitions for the MAM request packetizer: ring flit type, MAM header layout
// and packetizer FSM states.
package osd_mam_pktgen_pkg;

    localparam logic [5:0] MAM_REQ_TYPE  = 6'h10;
    localparam int unsigned HDR_RW        = 15;
    localparam int unsigned HDR_BURST     = 14;
    localparam int unsigned HDR_BEATS_MSB = 13;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit_t;

    typedef enum logic [2:0] {
        StIdle,
        StDest,
        StSrc,
        StHdr,
        StAddr,
        StData
    } state_e;

    // Beats field is zero for single-word requests.
    function automatic logic [15:0] hdr_flit(logic rw, logic burst, logic [13:0] beats);
        logic [15:0] f;
        f = '0;
        f[HDR_RW] = rw;
        f[HDR_BURST] = burst;
        f[HDR_BEATS_MSB:0] = burst ? beats : 14'd0;
        return f;
    endfunction

endpackage

// File: rtl/osd_mam_pktgen_if.sv
// Request, write-data and ring-output signals of the MAM packetizer.
interface osd_mam_pktgen_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                               req_valid;
    logic                               req_ready;
    logic                               req_rw;
    logic [ADDR_WIDTH-1:0]              req_addr;
    logic                               req_burst;
    logic [13:0]                        req_beats;
    logic                               wdata_valid;
    logic [DATA_WIDTH-1:0]              wdata;
    logic                               wdata_ready;
    osd_mam_pktgen_pkg::dii_flit_t      debug_out;
    logic                               debug_out_ready;

    modport master (
        output req_valid, req_rw, req_addr, req_burst, req_beats, wdata_valid, wdata,
               debug_out_ready,
        input  req_ready, wdata_ready, debug_out
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_burst, req_beats, wdata_valid, wdata,
               debug_out_ready,
        output req_ready, wdata_ready, debug_out
    );
endinterface

// File: rtl/mam_word_serializer.sv
// Splits a DATA_WIDTH word into 16-bit flits, MSB flit first. Flit 0 is taken straight from
// the incoming word so a word can be emitted the cycle it is accepted.
module mam_word_serializer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [15:0]           flit,
    output logic                  start,
    output logic                  last
);
    localparam int unsigned WF = DATA_WIDTH / 16;
    localparam int unsigned IW = (WF > 1) ? $clog2(WF) : 1;

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [IW-1:0]         idx_q, idx_d;

    always_comb begin
        start  = (idx_q == '0);
        last   = (idx_q == IW'(WF - 1));
        flit   = start ? word[DATA_WIDTH-1 -: 16] : sreg_q[DATA_WIDTH-1 -: 16];
        sreg_d = sreg_q;
        idx_d  = idx_q;
        if (step) begin
            sreg_d = start ? (word << 16) : (sreg_q << 16);
            idx_d  = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            idx_q  <= idx_d;
        end
    end

endmodule

// File: rtl/osd_mam_pktgen.sv
// Host-side MAM request packetizer: turns (addr, beats) plus a write-data stream into
// dest/src/header/address/data ring packets, splitting bursts at MAX_PKT_LEN flits.
module osd_mam_pktgen
    import osd_mam_pktgen_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MAX_PKT_LEN = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       id,
    input  logic [9:0]       mam_id,
    output logic             busy,
    osd_mam_pktgen_if.slave  bus
);
    localparam int unsigned WF  = DATA_WIDTH / 16;
    localparam int unsigned AF  = ADDR_WIDTH / 16;
    localparam int unsigned W0  = (MAX_PKT_LEN - 3 - AF) / WF;
    localparam int unsigned WC  = (MAX_PKT_LEN - 2) / WF;
    localparam int unsigned PW  = $clog2(WC + 1);
    localparam int unsigned AIW = (AF > 1) ? $clog2(AF) : 1;

    state_e                state_q, state_d;
    dii_flit_t             flit_q, flit_d;
    logic                  rw_q, rw_d;
    logic [15:0]           hdr_q, hdr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [13:0]           words_left_q, words_left_d;
    logic [PW-1:0]         pkt_words_q, pkt_words_d;
    logic [AIW-1:0]        addr_idx_q, addr_idx_d;
    logic                  first_q, first_d;
    logic                  rst_done_q;

    logic                  slot_free;
    logic                  ser_step, ser_start, ser_last;
    logic [15:0]           ser_flit;
    logic [13:0]           wl_n;
    logic [PW-1:0]         pw_n, cap;
    logic                  pkt_end;

    mam_word_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .step  (ser_step),
        .word  (bus.wdata),
        .flit  (ser_flit),
        .start (ser_start),
        .last  (ser_last)
    );

    assign slot_free     = !flit_q.valid || bus.debug_out_ready;
    assign bus.debug_out = flit_q;
    assign busy          = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        flit_d       = flit_q;
        rw_d         = rw_q;
        hdr_d        = hdr_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        pkt_words_d  = pkt_words_q;
        addr_idx_d   = addr_idx_q;
        first_d      = first_q;
        ser_step     = 1'b0;
        pkt_end      = 1'b0;
        bus.req_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        cap  = first_q ? PW'(W0) : PW'(WC);
        wl_n = ser_start ? words_left_q - 14'd1 : words_left_q;
        pw_n = ser_start ? pkt_words_q + 1'b1 : pkt_words_q;

        // A consumed flit leaves the slot empty unless something new is loaded below.
        if (bus.debug_out_ready) begin
            flit_d.valid = 1'b0;
            flit_d.last  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                bus.req_ready = rst_done_q;
                if (bus.req_valid && rst_done_q) begin
                    rw_d         = bus.req_rw;
                    hdr_d        = hdr_flit(bus.req_rw, bus.req_burst, bus.req_beats);
                    addr_d       = bus.req_addr;
                    words_left_d = !bus.req_rw ? 14'd0 : (bus.req_burst ? bus.req_beats : 14'd1);
                    pkt_words_d  = '0;
                    addr_idx_d   = '0;
                    first_d      = 1'b1;
                    state_d      = StDest;
                end
            end
            StDest: begin
                if (slot_free) begin
                    flit_d  = '{data: {6'h0, mam_id}, last: 1'b0, valid: 1'b1};
                    state_d = StSrc;
                end
            end
            StSrc: begin
                if (slot_free) begin
                    flit_d  = '{data: {MAM_REQ_TYPE, id}, last: 1'b0, valid: 1'b1};
                    state_d = first_q ? StHdr : StData;
                end
            end
            StHdr: begin
                if (slot_free) begin
                    flit_d  = '{data: hdr_q, last: 1'b0, valid: 1'b1};
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (slot_free) begin
                    flit_d     = '{data: addr_q[ADDR_WIDTH-1 -: 16], last: 1'b0, valid: 1'b1};
                    addr_d     = addr_q << 16;
                    addr_idx_d = addr_idx_q + 1'b1;
                    if (addr_idx_q == AIW'(AF - 1)) begin
                        // No room for a data word in the first packet forces an early close.
                        pkt_end     = !rw_q || (words_left_q == 14'd0) || (W0 == 0);
                        flit_d.last = pkt_end;
                        if (!rw_q || (words_left_q == 14'd0)) begin
                            state_d = StIdle;
                        end else if (pkt_end) begin
                            first_d = 1'b0;
                            state_d = StDest;
                        end else begin
                            state_d = StData;
                        end
                    end
                end
            end
            StData: begin
                bus.wdata_ready = slot_free && ser_start;
                if (slot_free && (!ser_start || bus.wdata_valid)) begin
                    ser_step = 1'b1;
                    flit_d   = '{data: ser_flit, last: 1'b0, valid: 1'b1};
                    if (ser_start) begin
                        words_left_d = wl_n;
                        pkt_words_d  = pw_n;
                    end
                    if (ser_last) begin
                        pkt_end     = (pw_n == cap) || (wl_n == 14'd0);
                        flit_d.last = pkt_end;
                        if (pkt_end) begin
                            pkt_words_d = '0;
                            first_d     = 1'b0;
                            state_d     = (wl_n == 14'd0) ? StIdle : StDest;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            flit_q       <= '0;
            rw_q         <= 1'b0;
            hdr_q        <= '0;
            addr_q       <= '0;
            words_left_q <= '0;
            pkt_words_q  <= '0;
            addr_idx_q   <= '0;
            first_q      <= 1'b0;
            rst_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_q       <= flit_d;
            rw_q         <= rw_d;
            hdr_q        <= hdr_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            pkt_words_q  <= pkt_words_d;
            addr_idx_q   <= addr_idx_d;
            first_q      <= first_d;
            rst_done_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_osd_mam_pktgen.sv
// Directed bench for osd_mam_pktgen: 16-bit and 32-bit data instances, flit streams compared
// against hand-computed packets.
module tb_osd_mam_pktgen;
    logic clk;
    logic rst_n;
    logic busy16, busy32;

    osd_mam_pktgen_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) m16 ();
    osd_mam_pktgen_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) m32 ();

    osd_mam_pktgen #(.DATA_WIDTH(16), .ADDR_WIDTH(32), .MAX_PKT_LEN(8)) dut16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .id     (10'd0),
        .mam_id (10'd1),
        .busy   (busy16),
        .bus    (m16.slave)
    );

    osd_mam_pktgen #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MAX_PKT_LEN(8)) dut32 (
        .clk    (clk),
        .rst_n  (rst_n),
        .id     (10'd0),
        .mam_id (10'd1),
        .busy   (busy32),
        .bus    (m32.slave)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] words[$];
    logic [16:0] got[$];
    logic [16:0] expq[$];
    int          widx;
    bit          req_pend, use32, rnd, saw_wready, prev_stall;
    bit          r_rw, r_burst;
    logic [31:0] r_addr;
    logic [13:0] r_beats;
    logic [16:0] prev_flit;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive on the falling edge, then sample what the next rising edge will see.
    task automatic step();
        logic        v, l, wr, rr;
        logic [15:0] d;
        logic [31:0] wd;
        bit          wv, dr;
        @(negedge clk);
        wv = (widx < words.size()) && (!rnd || ($urandom_range(0, 1) == 1));
        dr = !rnd || ($urandom_range(0, 1) == 1);
        wd = (widx < words.size()) ? words[widx] : 32'h0;
        m16.req_valid = req_pend && !use32;
        m32.req_valid = req_pend && use32;
        m16.req_rw = r_rw;       m32.req_rw = r_rw;
        m16.req_burst = r_burst; m32.req_burst = r_burst;
        m16.req_addr = r_addr;   m32.req_addr = r_addr;
        m16.req_beats = r_beats; m32.req_beats = r_beats;
        m16.wdata_valid = wv && !use32;
        m32.wdata_valid = wv && use32;
        m16.wdata = wd[15:0];
        m32.wdata = wd;
        m16.debug_out_ready = dr;
        m32.debug_out_ready = dr;
        #1;
        if (use32) begin
            v = m32.debug_out.valid; l = m32.debug_out.last; d = m32.debug_out.data;
            wr = m32.wdata_ready; rr = m32.req_ready;
        end else begin
            v = m16.debug_out.valid; l = m16.debug_out.last; d = m16.debug_out.data;
            wr = m16.wdata_ready; rr = m16.req_ready;
        end
        if (wr) saw_wready = 1'b1;
        if (prev_stall) begin
            check("hold_valid", {31'd0, v}, 32'd1);
            check("hold_flit", {15'd0, l, d}, {15'd0, prev_flit});
        end
        if (req_pend && rr) req_pend = 1'b0;
        if (wv && wr) widx++;
        if (v && dr) got.push_back({l, d});
        prev_stall = v && !dr;
        prev_flit = {l, d};
    endtask

    task automatic start(bit rw_i, bit burst_i, logic [31:0] addr_i, logic [13:0] beats_i,
                         bit u32, bit rnd_i);
        r_rw = rw_i; r_burst = burst_i; r_addr = addr_i; r_beats = beats_i;
        use32 = u32; rnd = rnd_i;
        req_pend = 1'b1; widx = 0; saw_wready = 1'b0;
        words.delete(); got.delete(); expq.delete();
    endtask

    task automatic run(string tag, int lim);
        int n = 0;
        while ((got.size() < expq.size() || req_pend) && n < lim) begin
            step();
            n++;
        end
        repeat (3) step();
        check({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            check($sformatf("%s_flit%0d", tag, i), {15'd0, got[i]}, {15'd0, expq[i]});
    endtask

    task automatic exp_t2();
        expq = '{17'h00001, 17'h04000, 17'h0c006, 17'h00000, 17'h00000, 17'h00000, 17'h00001,
                 17'h10002, 17'h00001, 17'h04000, 17'h00003, 17'h00004, 17'h10005};
        for (int i = 0; i < 6; i++) words.push_back(32'(i));
    endtask

    task automatic do_t1(string tag);
        start(1'b1, 1'b0, 32'h0, 14'd0, 1'b0, 1'b0);
        words.push_back(32'h000f);
        expq = '{17'h00001, 17'h04000, 17'h08000, 17'h00000, 17'h00000, 17'h1000f};
        run(tag, 100);
        check({tag, "_busy"}, {31'd0, busy16}, 32'd0);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        req_pend = 1'b0; use32 = 1'b0; rnd = 1'b0; prev_stall = 1'b0; widx = 0;
        r_rw = 1'b0; r_burst = 1'b0; r_addr = '0; r_beats = '0;
        m16.req_valid = 1'b0; m16.wdata_valid = 1'b0; m16.debug_out_ready = 1'b0;
        m32.req_valid = 1'b0; m32.wdata_valid = 1'b0; m32.debug_out_ready = 1'b0;
        m16.req_rw = 1'b0; m16.req_burst = 1'b0; m16.req_addr = '0; m16.req_beats = '0;
        m32.req_rw = 1'b0; m32.req_burst = 1'b0; m32.req_addr = '0; m32.req_beats = '0;
        m16.wdata = '0; m32.wdata = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'd0, m16.debug_out.valid}, 32'd0);
        check("rst_last", {31'd0, m16.debug_out.last}, 32'd0);
        check("rst_data", {16'd0, m16.debug_out.data}, 32'd0);
        check("rst_req_ready", {31'd0, m16.req_ready}, 32'd0);
        check("rst_wdata_ready", {31'd0, m16.wdata_ready}, 32'd0);
        check("rst_busy", {31'd0, busy16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("idle_req_ready", {31'd0, m16.req_ready}, 32'd1);

        // 1: single write
        do_t1("t1");

        // 2: burst write of 6 words splits into two packets
        start(1'b1, 1'b1, 32'h0, 14'd6, 1'b0, 1'b0);
        exp_t2();
        run("t2", 100);

        // 3: burst read never asks for data
        start(1'b0, 1'b1, 32'h0000_0100, 14'd4, 1'b0, 1'b0);
        expq = '{17'h00001, 17'h04000, 17'h04004, 17'h00000, 17'h10100};
        run("t3", 100);
        check("t3_wready", {31'd0, saw_wready}, 32'd0);

        // 4: 32-bit words, one word fits in the first packet
        start(1'b1, 1'b1, 32'h0, 14'd2, 1'b1, 1'b0);
        words.push_back(32'h1234_5678);
        words.push_back(32'h9abc_def0);
        expq = '{17'h00001, 17'h04000, 17'h0c002, 17'h00000, 17'h00000, 17'h01234, 17'h15678,
                 17'h00001, 17'h04000, 17'h09abc, 17'h1def0};
        run("t4", 100);
        check("t4_busy", {31'd0, busy32}, 32'd0);

        // 5: test 2 under random backpressure and write-data gaps
        start(1'b1, 1'b1, 32'h0, 14'd6, 1'b0, 1'b1);
        exp_t2();
        run("t5", 600);

        // 6: reset in the middle of test 2's data phase, then a clean single write
        start(1'b1, 1'b1, 32'h0, 14'd6, 1'b0, 1'b0);
        exp_t2();
        for (int n = 0; n < 50 && got.size() < 6; n++) step();
        check("t6_in_data", {31'd0, busy16}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, m16.debug_out.valid}, 32'd0);
        check("t6_rst_busy", {31'd0, busy16}, 32'd0);
        check("t6_rst_req_ready", {31'd0, m16.req_ready}, 32'd0);
        req_pend = 1'b0; words.delete(); got.delete(); prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_t1("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
